// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe : two-stage pipelined ALU with valid/ready handshakes on both sides.
//
// Stage 1 captures operands, opcode and tag. Stage 2 captures the computed
// result, the status flags and the tag. Both stages advance together whenever
// the output register is empty or being consumed. The block therefore holds up
// to two operations under back-pressure and sustains one operation per cycle
// when the consumer is always ready.
//
// Parameters
//   WIDTH  datapath width (power of two, 8..64)
//   TAG_W  width of the sideband tag returned with each result
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation presented on a, b, opcode, in_tag
//   in_ready   operation can be accepted this cycle (never depends on in_valid)
//   a, b       operands
//   opcode     0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA 8 SLT 9 SLTU
//              10 ROL 11 ROR, 12..15 illegal
//   in_tag     user tag
//   out_valid  result and flags valid
//   out_ready  consumer takes the result this cycle
//   result     operation result
//   out_tag    tag of the operation that produced result
//   zero, neg, carry, ovf, illegal  status flags for result
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_ROR  = 4'd11;

  // Stage 1 registers
  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [3:0]       s1_op_r;
  logic [TAG_W-1:0] s1_tag_r;

  // Stage 2 registers (drive the outputs directly)
  logic             s2_valid_r;
  logic [WIDTH-1:0] s2_res_r;
  logic [TAG_W-1:0] s2_tag_r;
  logic             s2_zero_r;
  logic             s2_neg_r;
  logic             s2_carry_r;
  logic             s2_ovf_r;
  logic             s2_ill_r;

  // Combinational datapath signals
  logic             adv_s;
  logic [SHW-1:0]   sh_s;
  logic [SHW:0]     inv_sh_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   dif_s;
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             ovf_s;
  logic             ill_s;
  logic             zero_s;

  // Handshake: both stages move when the output register is free or drained.
  always_comb begin
    adv_s    = !s2_valid_r || out_ready;
    in_ready = !s1_valid_r || adv_s;
  end

  // ALU: computes result and flags from the stage 1 registers.
  always_comb begin
    sh_s     = s1_b_r[SHW-1:0];
    // Complementary shift for rotates; an amount of WIDTH shifts everything out.
    inv_sh_s = (SHW+1)'(WIDTH) - {1'b0, sh_s};
    sum_s    = {1'b0, s1_a_r} + {1'b0, s1_b_r};
    // Bit WIDTH of the widened difference is the unsigned borrow.
    dif_s    = {1'b0, s1_a_r} - {1'b0, s1_b_r};
    res_s    = {WIDTH{1'b0}};
    carry_s  = 1'b0;
    ovf_s    = 1'b0;
    ill_s    = 1'b0;
    case (s1_op_r)
      OP_ADD: begin
        res_s   = sum_s[WIDTH-1:0];
        carry_s = sum_s[WIDTH];
        ovf_s   = (s1_a_r[WIDTH-1] == s1_b_r[WIDTH-1]) &&
                  (sum_s[WIDTH-1] != s1_a_r[WIDTH-1]);
      end
      OP_SUB: begin
        res_s   = dif_s[WIDTH-1:0];
        carry_s = dif_s[WIDTH];
        ovf_s   = (s1_a_r[WIDTH-1] != s1_b_r[WIDTH-1]) &&
                  (dif_s[WIDTH-1] != s1_a_r[WIDTH-1]);
      end
      OP_AND:  res_s = s1_a_r & s1_b_r;
      OP_OR:   res_s = s1_a_r | s1_b_r;
      OP_XOR:  res_s = s1_a_r ^ s1_b_r;
      OP_SLL:  res_s = s1_a_r << sh_s;
      OP_SRL:  res_s = s1_a_r >> sh_s;
      OP_SRA:  res_s = $unsigned($signed(s1_a_r) >>> sh_s);
      OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(s1_a_r) < $signed(s1_b_r))};
      OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, (s1_a_r < s1_b_r)};
      OP_ROL:  res_s = (s1_a_r << sh_s) | (s1_a_r >> inv_sh_s);
      OP_ROR:  res_s = (s1_a_r >> sh_s) | (s1_a_r << inv_sh_s);
      default: begin
        res_s = {WIDTH{1'b0}};
        ill_s = 1'b1;
      end
    endcase
    // Flags derive from the same result they are registered with.
    zero_s = (res_s == {WIDTH{1'b0}});
  end

  // Stage 1: capture an accepted operation; empties when it moves on unreplaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_op_r    <= 4'd0;
      s1_tag_r   <= {TAG_W{1'b0}};
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_a_r   <= a;
        s1_b_r   <= b;
        s1_op_r  <= opcode;
        s1_tag_r <= in_tag;
      end
    end
  end

  // Stage 2: capture result and flags; holds steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_res_r   <= {WIDTH{1'b0}};
      s2_tag_r   <= {TAG_W{1'b0}};
      s2_zero_r  <= 1'b1;
      s2_neg_r   <= 1'b0;
      s2_carry_r <= 1'b0;
      s2_ovf_r   <= 1'b0;
      s2_ill_r   <= 1'b0;
    end else if (adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_res_r   <= res_s;
        s2_tag_r   <= s1_tag_r;
        s2_zero_r  <= zero_s;
        s2_neg_r   <= res_s[WIDTH-1];
        s2_carry_r <= carry_s;
        s2_ovf_r   <= ovf_s;
        s2_ill_r   <= ill_s;
      end
    end
  end

  // Output mapping
  always_comb begin
    out_valid = s2_valid_r;
    result    = s2_res_r;
    out_tag   = s2_tag_r;
    zero      = s2_zero_r;
    neg       = s2_neg_r;
    carry     = s2_carry_r;
    ovf       = s2_ovf_r;
    illegal   = s2_ill_r;
  end

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe : self-checking bench for alu_pipe (WIDTH=32, TAG_W=4).
// A reference model computes each accepted operation; a monitor compares every
// delivered result in order, checks latency and stall stability, and directed
// vectors pin both the DUT and the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  opcode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  out_tag;
  logic        zero, neg, carry, ovf, illegal;

  alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_tag(out_tag), .zero(zero), .neg(neg), .carry(carry), .ovf(ovf),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;   // {zero, neg, carry, ovf, illegal}
    logic [3:0]  tag;
    int          acc;
  } ent_t;

  ent_t        exp_q[$];
  logic [3:0]  out_log[$];
  int          cyc        = 0;
  int          last_stall = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference model: returns {result, zero, neg, carry, ovf, illegal}.
  function automatic logic [36:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y);
    longint unsigned ux, uy, t;
    longint          sx, sy, s;
    int              sh;
    logic [31:0]     r;
    logic            c, v, il;
    ux = x; uy = y; sx = $signed(x); sy = $signed(y);
    sh = int'(y[4:0]);
    c = 1'b0; v = 1'b0; il = 1'b0; r = 32'd0;
    case (op)
      4'd0: begin
        t = ux + uy; r = t[31:0]; c = t[32];
        s = sx + sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        r = x - y; c = (ux < uy);
        s = sx - sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = x << sh;
      4'd6: r = x >> sh;
      4'd7: begin
        r = x >> sh;
        if (x[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      4'd8: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd9: r = (ux < uy) ? 32'd1 : 32'd0;
      4'd10: begin
        r = x;
        for (int k = 0; k < sh; k++) r = {r[30:0], r[31]};
      end
      4'd11: begin
        r = x;
        for (int k = 0; k < sh; k++) r = {r[0], r[31:1]};
      end
      default: begin r = 32'd0; il = 1'b1; end
    endcase
    return {r, (r == 32'd0), r[31], c, v, il};
  endfunction

  // Monitor: scoreboards accepts and delivered results between clock edges.
  logic        hold_v = 1'b0;
  logic [40:0] hold_val;
  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("stall_stable", {out_valid, result, zero, neg, carry, ovf, illegal, out_tag},
                      {1'b1, hold_val});
      if (out_valid && !out_ready) last_stall = cyc;
      if (out_valid && out_ready) begin
        chk("out_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          ent_t e;
          e = exp_q.pop_front();
          chk("result", result, e.res);
          chk("flags", {zero, neg, carry, ovf, illegal}, e.fl);
          chk("tag", out_tag, e.tag);
          if (last_stall < e.acc) chk("latency", 64'(cyc - e.acc), 64'd2);
          out_log.push_back(out_tag);
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_val = {result, zero, neg, carry, ovf, illegal, out_tag};
      if (in_valid && in_ready) begin
        ent_t n;
        logic [36:0] m;
        m = model(opcode, a, b);
        n.res = m[36:5]; n.fl = m[4:0]; n.tag = in_tag; n.acc = cyc;
        exp_q.push_back(n);
      end
    end
  end

  // Single op with out_ready=1: pins latency and hand-computed outputs.
  task automatic op_chk(input string nm, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [3:0] tg,
                        input logic [31:0] er, input logic [4:0] ef);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; opcode = op; a = x; b = y; in_tag = tg;
    @(negedge clk);
    in_valid = 1'b0;
    #3 chk({nm, "_not_early"}, out_valid, 1'b0);
    @(negedge clk);
    #3;
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_res"}, result, er);
    chk({nm, "_flags"}, {zero, neg, carry, ovf, illegal}, ef);
    chk({nm, "_tag"}, out_tag, tg);
  endtask

  // Presents one op and waits (bounded) until it is accepted.
  task automatic push_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] tg, input bit rnd);
    int g;
    in_valid = 1'b1; opcode = op; a = x; b = y; in_tag = tg;
    out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    g = 0;
    #1;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      g++;
      #1;
    end
    if (g >= 100) chk("accept_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  task automatic drain();
    int g;
    in_valid = 1'b0; out_ready = 1'b1; g = 0;
    while (exp_q.size() != 0 && g < 30) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  logic [31:0] va [8] = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000,
                          32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_00FF};

  initial begin
    time t0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 32'd0; b = 32'd0; opcode = 4'd0; in_tag = 4'd0;
    #7;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_zero", zero, 1'b1);
    chk("rst_outs", {result, out_tag, neg, carry, ovf, illegal}, 40'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #3 chk("in_ready_after_rst", in_ready, 1'b1);

    // Model pinned against hand-computed values
    chk("model_sub", model(4'd1, 32'h0, 32'h1), {32'hFFFF_FFFF, 5'b01100});
    chk("model_rol", model(4'd10, 32'h8000_0001, 32'h4), {32'h0000_0018, 5'b00000});
    chk("model_sra", model(4'd7, 32'h8000_0000, 32'h24), {32'hF800_0000, 5'b01000});

    // Directed vectors, flags = {zero, neg, carry, ovf, illegal}
    op_chk("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 4'd1, 32'h0, 5'b10100);
    op_chk("add_ovf",  4'd0, 32'h7FFF_FFFF, 32'h1, 4'd2, 32'h8000_0000, 5'b01010);
    op_chk("add_nn",   4'd0, 32'h8000_0000, 32'h8000_0000, 4'd3, 32'h0, 5'b10110);
    op_chk("sub_brw",  4'd1, 32'h0, 32'h1, 4'd4, 32'hFFFF_FFFF, 5'b01100);
    op_chk("sub_eq",   4'd1, 32'h5, 32'h5, 4'd5, 32'h0, 5'b10000);
    op_chk("and",      4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd6, 32'hF000_F000, 5'b01000);
    op_chk("or_zero",  4'd3, 32'h0, 32'h0, 4'd7, 32'h0, 5'b10000);
    op_chk("xor",      4'd4, 32'h1234_5678, 32'h1234_5678, 4'd8, 32'h0, 5'b10000);
    op_chk("sll",      4'd5, 32'h1, 32'h21, 4'd9, 32'h2, 5'b00000);
    op_chk("srl",      4'd6, 32'h8000_0000, 32'h1F, 4'd10, 32'h1, 5'b00000);
    op_chk("sra",      4'd7, 32'h8000_0000, 32'h24, 4'd11, 32'hF800_0000, 5'b01000);
    op_chk("slt",      4'd8, 32'hFFFF_FFFF, 32'h1, 4'd12, 32'h1, 5'b00000);
    op_chk("sltu",     4'd9, 32'hFFFF_FFFF, 32'h1, 4'd13, 32'h0, 5'b10000);
    op_chk("rol",      4'd10, 32'h8000_0001, 32'h4, 4'd14, 32'h18, 5'b00000);
    op_chk("ror",      4'd11, 32'h1, 32'h1, 4'd15, 32'h8000_0000, 5'b01000);
    op_chk("illegal",  4'd13, 32'h5, 32'h3, 4'd0, 32'h0, 5'b10001);
    drain();

    // Full-throughput burst: 32 ops in 32 cycles
    @(negedge clk);
    t0 = $time;
    for (int i = 0; i < 32; i++) push_op(4'(i % 16), va[i % 8], va[(i * 3 + 1) % 8], 4'(i), 1'b0);
    chk("throughput_cycles", 64'(($time - t0) / 10), 64'd32);
    drain();

    // Burst under random back-pressure
    for (int i = 0; i < 32; i++) push_op(4'(i % 12), va[(i + 5) % 8], va[(i * 5) % 8], 4'(i), 1'b1);
    drain();

    // Back-pressure: three ops with out_ready low, only two fit
    out_log.delete();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; opcode = 4'd0; a = 32'd1; b = 32'd1; in_tag = 4'd1;
    #1 chk("bp_acc1", in_ready, 1'b1);
    @(negedge clk);
    a = 32'd2; in_tag = 4'd2;
    #1 chk("bp_acc2", in_ready, 1'b1);
    @(negedge clk);
    a = 32'd3; in_tag = 4'd3;
    #1 chk("bp_third_blocked", in_ready, 1'b0);
    @(negedge clk);
    #1 chk("bp_still_blocked", {in_ready, out_valid, out_tag}, {1'b0, 1'b1, 4'd1});
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bp_ready_on_release", in_ready, 1'b1);
    @(negedge clk);
    drain();
    chk("bp_count", 64'(out_log.size()), 64'd3);
    if (out_log.size() == 3) chk("bp_order", {out_log[0], out_log[1], out_log[2]}, 12'h123);

    // Asynchronous reset with both stages full
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; opcode = 4'd0; a = 32'h10; b = 32'h1; in_tag = 4'd5;
    @(negedge clk);
    in_tag = 4'd6;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("full_before_rst", {out_valid, in_ready}, 2'b10);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_zero", zero, 1'b1);
    chk("async_outs", {result, out_tag}, 36'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #3 chk("rel_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #3 chk("no_stale", out_valid, 1'b0);
    end
    op_chk("post_rst", 4'd0, 32'h2, 32'h3, 4'd9, 32'h5, 5'b00000);
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
